// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory responder: memory-op encodings,
// FSM state encodings, byte-enable patterns and op-class helpers.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_dmem.sv
// DEPTH x 32 data RAM: synchronous write with per-byte enables and
// synchronous read (data appears the cycle after re is sampled).
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: one request at a time against a byte-enabled RAM,
// returning extended load data. Optional macro MEM_MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_op_i,
  input  logic [4:0]  reg_waddr_i,
  output logic        resp_valid_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        stallreq_o
);

  state_e        state;
  logic [3:0]    op_p0;
  logic [1:0]    off_p0;
  logic [4:0]    rd_p0;

  logic          accept;
  logic          load_in;
  logic          store_in;
  logic          misal_in;
  logic          ram_we;
  logic          ram_re;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          unused_addr_hi;

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] be;
    be = BE_NONE;
    case (op)
      MEM_SB:  be = BE_BYTE << off;
      MEM_SH:  be = off[1] ? (BE_HALF << 2) : BE_HALF;
      MEM_SW:  be = BE_WORD;
      default: be = BE_NONE;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (op)
      MEM_SB:  r = {4{d[7:0]}};
      MEM_SH:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[7:0];
    case (off)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    r = '0;
    case (op)
      MEM_LB:  r = {{24{b[7]}}, b};
      MEM_LBU: r = {24'b0, b};
      MEM_LH:  r = {{16{h[15]}}, h};
      MEM_LHU: r = {16'b0, h};
      MEM_LW:  r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign req_ready_o    = (state == S_IDLE);
  assign accept         = req_valid_i & req_ready_o;
  assign load_in        = op_is_load(mem_op_i);
  assign store_in       = op_is_store(mem_op_i) & mem_we_i;
  assign stallreq_o     = (state != S_IDLE) | (req_valid_i & load_in);
  // Address bits above the RAM index are deliberately dropped (wraparound).
  assign unused_addr_hi = ^mem_addr_i[31:AW+2];

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misal_in = 1'b0;
    case (mem_op_i)
      MEM_LH, MEM_LHU, MEM_SH: misal_in = mem_addr_i[0];
      MEM_LW, MEM_SW:          misal_in = |mem_addr_i[1:0];
      default:                 misal_in = 1'b0;
    endcase
    misal_in = misal_in & (load_in | store_in);
  end
`else
  assign misal_in = 1'b0;
`endif

  always_comb begin
    ram_we    = accept & store_in & ~misal_in;
    ram_re    = accept & load_in & ~misal_in;
    ram_addr  = mem_addr_i[AW+1:2];
    ram_be    = store_be(mem_op_i, mem_addr_i[1:0]);
    ram_wdata = store_lanes(mem_op_i, mem_data_i);
  end

  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage p0: request attributes captured at acceptance (data, not reset)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_p0  <= mem_op_i;
      off_p0 <= mem_addr_i[1:0];
      rd_p0  <= reg_waddr_i;
    end
  end

  // Response stage: control FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      resp_valid_o <= 1'b0;
      reg_we_o     <= 1'b0;
      reg_waddr_o  <= '0;
      reg_wdata_o  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid_o <= 1'b0;
          if (accept) begin
            if (load_in && !misal_in) begin
              state <= S_READ;
            end else begin
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
              reg_we_o     <= 1'b0;
              reg_waddr_o  <= reg_waddr_i;
              reg_wdata_o  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
              misalign_o   <= misal_in;
`endif
            end
          end
        end
        S_READ: begin
          state        <= S_RESP;
          resp_valid_o <= 1'b1;
          reg_we_o     <= 1'b1;
          reg_waddr_o  <= rd_p0;
          reg_wdata_o  <= load_extend(op_p0, off_p0, ram_rdata);
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_o   <= 1'b0;
`endif
        end
        S_RESP: begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses; a negedge monitor pops and compares on every resp_valid_o.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [3:0]  mem_op;
  logic [4:0]  rd_in;
  logic        resp_valid;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        stallreq;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
  } resp_t;

  resp_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .mem_addr_i   (mem_addr),
    .mem_data_i   (mem_data),
    .mem_we_i     (mem_we),
    .mem_op_i     (mem_op),
    .reg_waddr_i  (rd_in),
    .resp_valid_o (resp_valid),
    .reg_we_o     (reg_we),
    .reg_waddr_o  (reg_waddr),
    .reg_wdata_o  (reg_wdata),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_o   (misalign),
`endif
    .stallreq_o   (stallreq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic resp_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic mis);
    resp_t r;
    r.we = we; r.waddr = wa; r.wdata = wd; r.mis = mis;
    return r;
  endfunction

  // Monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_we", {31'b0, reg_we}, {31'b0, e.we});
        check("resp_waddr", {27'b0, reg_waddr}, {27'b0, e.waddr});
        check("resp_wdata", reg_wdata, e.wdata);
`ifdef MEM_MISALIGN_CHECK_EN
        check("resp_misalign", {31'b0, misalign}, {31'b0, e.mis});
`endif
      end
    end
  end

  // Issue one request when idle, then measure cycles from accept to response.
  task automatic do_req(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input resp_t e,
                        input int exp_lat);
    int lat;
    int waited;
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_data = data; rd_in = rd;
    mem_we = op_is_store(op); req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0; mem_we = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (resp_valid !== 1'b1 && lat < 8);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_addr = '0; mem_data = '0;
    mem_we = 1'b0; mem_op = MEM_NOP; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_reg_we", {31'b0, reg_we}, 32'd0);
    check("rst_wdata", reg_wdata, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_stall", {31'b0, stallreq}, 32'd0);

    // Word store/load
    do_req("sw10", MEM_SW, 32'h10, 32'hDEADBEEF, 5'd0, mk(0, 0, 0, 0), 1);
    do_req("lw10", MEM_LW, 32'h10, 32'h0, 5'd5, mk(1, 5, 32'hDEADBEEF, 0), 2);

    // Byte store into a known word, then byte loads
    do_req("sw_init", MEM_SW, 32'h10, 32'h11223344, 5'd0, mk(0, 0, 0, 0), 1);
    do_req("sb13", MEM_SB, 32'h13, 32'hABCDEF80, 5'd3, mk(0, 3, 0, 0), 1);
    do_req("lb13", MEM_LB, 32'h13, 32'h0, 5'd1, mk(1, 1, 32'hFFFFFF80, 0), 2);
    do_req("lbu13", MEM_LBU, 32'h13, 32'h0, 5'd2, mk(1, 2, 32'h00000080, 0), 2);
    do_req("lw_sb", MEM_LW, 32'h10, 32'h0, 5'd3, mk(1, 3, 32'h80223344, 0), 2);

    // Halfword store to upper half, low half must survive
    do_req("sh12", MEM_SH, 32'h12, 32'h12348001, 5'd0, mk(0, 0, 0, 0), 1);
    do_req("lh12", MEM_LH, 32'h12, 32'h0, 5'd4, mk(1, 4, 32'hFFFF8001, 0), 2);
    do_req("lhu12", MEM_LHU, 32'h12, 32'h0, 5'd6, mk(1, 6, 32'h00008001, 0), 2);
    do_req("lw_sh", MEM_LW, 32'h10, 32'h0, 5'd7, mk(1, 7, 32'h80013344, 0), 2);
    do_req("lb10", MEM_LB, 32'h10, 32'h0, 5'd8, mk(1, 8, 32'h00000044, 0), 2);
    do_req("lh10", MEM_LH, 32'h10, 32'h0, 5'd9, mk(1, 9, 32'h00003344, 0), 2);

    // Misaligned accesses
    do_req("sw20", MEM_SW, 32'h20, 32'hCAFEF00D, 5'd0, mk(0, 0, 0, 0), 1);
`ifdef MEM_MISALIGN_CHECK_EN
    do_req("lw11", MEM_LW, 32'h11, 32'h0, 5'd10, mk(0, 10, 32'h0, 1), 1);
    do_req("sw22", MEM_SW, 32'h22, 32'h12345678, 5'd0, mk(0, 0, 0, 1), 1);
    do_req("lw20", MEM_LW, 32'h20, 32'h0, 5'd11, mk(1, 11, 32'hCAFEF00D, 0), 2);
`else
    do_req("lw11", MEM_LW, 32'h11, 32'h0, 5'd10, mk(1, 10, 32'h80013344, 0), 2);
    do_req("sw22", MEM_SW, 32'h22, 32'h12345678, 5'd0, mk(0, 0, 0, 0), 1);
    do_req("lw20", MEM_LW, 32'h20, 32'h0, 5'd11, mk(1, 11, 32'h12345678, 0), 2);
`endif

    // Address wrap modulo DEPTH words
    do_req("sw_wrap", MEM_SW, 32'h1030, 32'hA5A5A5A5, 5'd0, mk(0, 0, 0, 0), 1);
    do_req("lw_wrap", MEM_LW, 32'h30, 32'h0, 5'd12, mk(1, 12, 32'hA5A5A5A5, 0), 2);

    // NOP and unknown op
    do_req("nop", MEM_NOP, 32'h10, 32'hFFFFFFFF, 5'd7, mk(0, 7, 0, 0), 1);
    do_req("unk", 4'hF, 32'h10, 32'hFFFFFFFF, 5'd13, mk(0, 13, 0, 0), 1);

    // Reset while a load sits in S_READ: response must be dropped
    @(negedge clk);
    mem_op = MEM_LW; mem_addr = 32'h10; rd_in = 5'd14; mem_we = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_reg_we", {31'b0, reg_we}, 32'd0);
    check("midrst_waddr", {27'b0, reg_waddr}, 32'd0);
    check("midrst_wdata", reg_wdata, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    do_req("lw_after_rst", MEM_LW, 32'h10, 32'h0, 5'd15, mk(1, 15, 32'h80013344, 0), 2);

    // Back-to-back: SW then LW held valid
    @(negedge clk);
    mem_op = MEM_SW; mem_addr = 32'h40; mem_data = 32'h600DF00D; rd_in = 5'd0;
    mem_we = 1'b1; req_valid = 1'b1;
    check("b2b_store_stall", {31'b0, stallreq}, 32'd0);
    exp_q.push_back(mk(0, 0, 0, 0));
    @(posedge clk);
    #1 mem_op = MEM_LW; mem_we = 1'b0; rd_in = 5'd9;
    exp_q.push_back(mk(1, 9, 32'h600DF00D, 0));
    @(negedge clk);
    check("b2b_busy_ready", {31'b0, req_ready}, 32'd0);
    check("b2b_busy_stall", {31'b0, stallreq}, 32'd1);
    @(negedge clk);
    check("b2b_idle_ready", {31'b0, req_ready}, 32'd1);
    check("b2b_idle_stall", {31'b0, stallreq}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_read_stall", {31'b0, stallreq}, 32'd1);
    check("b2b_read_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("b2b_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("b2b_resp_stall", {31'b0, stallreq}, 32'd1);
    @(negedge clk);
    check("b2b_done_stall", {31'b0, stallreq}, 32'd0);
    check("b2b_pulse_width", {31'b0, resp_valid}, 32'd0);

    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
